// File: rtl/alu_z_stage.sv
// Z register stage behind the combinational ALU: captures the 64-bit ALU result
// into ZHI/ZLO, and runs a multi-cycle signed restoring divide for DIV_OP.
module alu_z_stage #(
  parameter int unsigned     DATA_WIDTH = 32,
  parameter logic [4:0]      DIV_OP     = 5'd6
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    start,
  input  logic [4:0]              op,
  input  logic [DATA_WIDTH-1:0]   A,
  input  logic [DATA_WIDTH-1:0]   B,
  input  logic [2*DATA_WIDTH-1:0] alu_result,
  input  logic                    ZHIout,
  input  logic                    ZLOout,
  output logic [DATA_WIDTH-1:0]   bus_out,
  output logic [DATA_WIDTH-1:0]   ZHI,
  output logic [DATA_WIDTH-1:0]   ZLO,
  output logic                    busy,
  output logic                    done,
  output logic                    div_zero
);

  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   zhi_q, zhi_d;
  logic [DATA_WIDTH-1:0]   zlo_q, zlo_d;
  logic [DATA_WIDTH-1:0]   rem_q, rem_d;
  logic [DATA_WIDTH-1:0]   quo_q, quo_d;
  logic [DATA_WIDTH-1:0]   dvs_q, dvs_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    sq_q, sq_d;
  logic                    sr_q, sr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    dz_q, dz_d;

  logic [DATA_WIDTH-1:0]   abs_a, abs_b;
  logic [DATA_WIDTH:0]     rem_sh, diff;

  assign abs_a  = A[DATA_WIDTH-1] ? -A : A;
  assign abs_b  = B[DATA_WIDTH-1] ? -B : B;
  // One extra bit so the trial subtraction's sign shows whether to restore.
  assign rem_sh = {rem_q, quo_q[DATA_WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    zhi_d   = zhi_q;
    zlo_d   = zlo_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (op != DIV_OP) begin
            {zhi_d, zlo_d} = alu_result;
            done_d         = 1'b1;
          end else if (B == '0) begin
            zlo_d  = '1;
            zhi_d  = A;
            dz_d   = 1'b1;
            done_d = 1'b1;
          end else begin
            quo_d   = abs_a;
            dvs_d   = abs_b;
            rem_d   = '0;
            sq_d    = A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1];
            sr_d    = A[DATA_WIDTH-1];
            cnt_d   = CW'(DATA_WIDTH);
            busy_d  = 1'b1;
            state_d = DIV;
          end
        end
      end
      DIV: begin
        quo_d = {quo_q[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
        rem_d = diff[DATA_WIDTH] ? rem_sh[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        zlo_d   = sq_q ? -quo_q : quo_q;
        zhi_d   = sr_q ? -rem_q : rem_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        dz_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      zhi_q   <= '0;
      zlo_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      zhi_q   <= zhi_d;
      zlo_q   <= zlo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign ZHI      = zhi_q;
  assign ZLO      = zlo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign bus_out  = ZHIout ? zhi_q : (ZLOout ? zlo_q : '0);

endmodule
